boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 196 +++++++++++++++++++
 tb/tb_boot_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
//
// Receives a boot image as a byte stream and writes it into instruction
// memory one 32-bit word at a time. The CPU is held in reset until the
// image has loaded and its checksum has matched.
//
// Image format:
//   - N: 16-bit word count, little-endian.
//   - 4*N payload bytes. Each word is little-endian.
//   - 1 checksum byte. It is the XOR of all payload bytes.
//
// Ports:
//   clk          clock; all state changes on its rising edge
//   rst          synchronous, active-high reset
//   rx_data      incoming image byte
//   rx_valid     rx_data holds a byte
//   rx_ready     block will accept a byte (byte consumed when valid & ready)
//   imem_waddr   instruction-memory word address
//   imem_wdata   instruction word to write
//   imem_wren    single-cycle instruction-memory write strobe
//   cpu_rst      holds the CPU in reset while high
//   done         image loaded and checksum matched
//   err          image rejected (oversize or checksum mismatch)
// -----------------------------------------------------------------------------
module boot_loader #(
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [AWIDTH-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              imem_wren,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  // Largest legal word count is 2^AWIDTH. The comparison is done at
  // 17 bits so that AWIDTH = 16 still fits.
  localparam logic [16:0] MAX_WORDS = 17'd1 << AWIDTH;

  state_t              state_q, state_d;
  logic [15:0]         n_q, n_d;
  logic [1:0]          lane_q, lane_d;
  logic [AWIDTH-1:0]   word_q, word_d;
  logic [23:0]         buf_q, buf_d;      // bytes 0..2 of the word being built
  logic [7:0]          xor_q, xor_d;
  logic                wren_q, wren_d;
  logic [AWIDTH-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept;
  logic [15:0]         n_full;
  logic                last_word;

  // The reset term keeps the handshake closed while rst is asserted.
  // As a result, no byte is consumed on a reset edge.
  assign rx_ready = !rst && (state_q == HDR0 || state_q == HDR1 ||
                             state_q == DATA || state_q == CSUM);
  assign accept   = rx_valid && rx_ready;

  // Word count as it stands once the high header byte arrives.
  assign n_full    = {rx_data, n_q[7:0]};
  assign last_word = (16'(word_q) == (n_q - 16'd1));

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    lane_d    = lane_q;
    word_d    = word_q;
    buf_d     = buf_q;
    xor_d     = xor_q;
    wren_d    = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;

    case (state_q)
      HDR0: begin
        // Start every image from a clean accumulator and counters.
        xor_d  = 8'h00;
        lane_d = 2'd0;
        word_d = '0;
        if (accept) begin
          n_d     = {8'h00, rx_data};
          state_d = HDR1;
        end
      end

      HDR1: begin
        if (accept) begin
          n_d = n_full;
          if ({1'b0, n_full} > MAX_WORDS) begin
            state_d = ERR;
          end else if (n_full == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (accept) begin
          xor_d  = xor_q ^ rx_data;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: buf_d[7:0]   = rx_data;
            2'd1: buf_d[15:8]  = rx_data;
            2'd2: buf_d[23:16] = rx_data;
            default: begin
              wren_d  = 1'b1;
              waddr_d = word_q;
              wdata_d = {rx_data, buf_q};
              // The word counter may wrap after the last word of a full-size
              // image. That is harmless because the FSM leaves DATA here.
              word_d  = word_q + 1'b1;
              if (last_word) begin
                state_d = CSUM;
              end
            end
          endcase
        end
      end

      CSUM: begin
        if (accept) begin
          state_d = (rx_data == xor_q) ? DONE : ERR;
        end
      end

      default: begin
        // DONE and ERR are terminal until reset.
      end
    endcase

    // The status flags change on the same edge as the state transition.
    // They are therefore visible in the cycle after the deciding byte.
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERR);
    cpu_rst_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HDR0;
      n_q       <= 16'h0000;
      lane_q    <= 2'd0;
      word_q    <= '0;
      buf_q     <= 24'h000000;
      xor_q     <= 8'h00;
      wren_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= 32'h00000000;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      lane_q    <= lane_d;
      word_q    <= word_d;
      buf_q     <= buf_d;
      xor_q     <= xor_d;
      wren_q    <= wren_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign imem_wren  = wren_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
//
// Testbench for boot_loader. It drives directed and random images into the
// design. Expected writes and the final outcome are derived from the image
// format itself.
// -----------------------------------------------------------------------------
module tb_boot_loader;

  localparam int AW = 8;

  typedef logic [7:0]     bq_t[$];
  typedef logic [AW+31:0] wr_t;

  logic          clk;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          imem_wren;
  logic          cpu_rst;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;

  wr_t got_wr[$];
  wr_t exp_wr[$];
  int  exp_len;
  bit  exp_done;

  boot_loader #(.AWIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .imem_wren (imem_wren),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every strobed write. A strobe longer than one cycle shows up
  // as an extra entry.
  always @(negedge clk) begin
    if (imem_wren === 1'b1) got_wr.push_back({imem_waddr, imem_wdata});
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decode the image by its format rules.
  task automatic model(input bq_t img);
    int   n;
    logic [7:0]  x;
    logic [31:0] w;
    exp_wr.delete();
    n = int'(img[0]) + 256 * int'(img[1]);
    if (n > (1 << AW)) begin
      exp_len  = 2;
      exp_done = 0;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++) begin
        w = w | (32'(img[2 + 4*k + b]) << (8*b));
        x = x ^ img[2 + 4*k + b];
      end
      exp_wr.push_back({k[AW-1:0], w});
    end
    exp_len  = 2 + 4*n + 1;
    exp_done = (img[exp_len-1] == x);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Offer one byte until it is accepted. On each cycle, valid is high
  // with probability pct percent.
  task automatic send_byte(input logic [7:0] b, input int pct);
    bit acc = 0;
    int cyc = 0;
    while (!acc && cyc < 300) begin
      rx_data  = b;
      rx_valid = ($urandom_range(99) < pct);
      @(negedge clk);
      acc = (rx_valid === 1'b1) && (rx_ready === 1'b1);
      @(posedge clk);
      #1;
      cyc++;
    end
    rx_valid = 1'b0;
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic run_image(input string name, input bq_t img, input int pct,
                           input int gap_at, input int gap_len);
    int nw;
    model(img);
    for (int i = 0; i < exp_len; i++) begin
      if (i == gap_at) begin
        rx_valid = 1'b0;
        repeat (gap_len) begin @(posedge clk); #1; end
      end
      send_byte(img[i], pct);
    end
    // Status must already reflect the final byte in this cycle.
    chk({name, "_done"},    64'(done),     64'(exp_done));
    chk({name, "_err"},     64'(err),      64'(!exp_done));
    chk({name, "_cpu_rst"}, 64'(cpu_rst),  64'(!exp_done));
    chk({name, "_ready"},   64'(rx_ready), 64'd0);
    // Further bytes must be ignored.
    rx_valid = 1'b1;
    repeat (4) begin
      rx_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    chk({name, "_done_hold"}, 64'(done), 64'(exp_done));
    nw = exp_wr.size();
    chk({name, "_nwr"}, 64'(got_wr.size()), 64'(nw));
    for (int i = 0; i < nw && i < got_wr.size(); i++) begin
      chk($sformatf("%s_wr%0d", name, i), 64'(got_wr[i]), 64'(exp_wr[i]));
    end
    $display("image %s: n_bytes=%0d writes=%0d done=%0b err=%0b", name, exp_len,
             got_wr.size(), done, err);
  endtask

  bq_t img;
  bq_t base;
  logic [7:0] x;

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    base     = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h01, 8'h20,
                 8'h08, 8'h00, 8'h00, 8'h00, 8'h3A};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_ready",   64'(rx_ready),   64'd1);
    chk("rst_cpu_rst", 64'(cpu_rst),    64'd1);
    chk("rst_done",    64'(done),       64'd0);
    chk("rst_err",     64'(err),        64'd0);
    chk("rst_wren",    64'(imem_wren),  64'd0);
    chk("rst_waddr",   64'(imem_waddr), 64'd0);
    chk("rst_wdata",   64'(imem_wdata), 64'd0);
    @(posedge clk); #1;

    // Known-good two-word image
    got_wr.delete();
    run_image("good", base, 100, -1, 0);
    chk("good_wr0_lit", 64'(got_wr.size() > 0 ? got_wr[0] : '0), 64'({8'h00, 32'h20010013}));
    chk("good_wr1_lit", 64'(got_wr.size() > 1 ? got_wr[1] : '0), 64'({8'h01, 32'h00000008}));

    // Same image, bad checksum
    do_reset(); got_wr.delete();
    img = base; img[10] = 8'h3B;
    run_image("badcsum", img, 100, -1, 0);

    // Empty image
    do_reset(); got_wr.delete();
    img = '{8'h00, 8'h00, 8'h00};
    run_image("empty", img, 100, -1, 0);

    // Oversize header (N = 257)
    do_reset(); got_wr.delete();
    img = '{8'h01, 8'h01};
    run_image("oversize", img, 100, -1, 0);

    // Random valid toggling with a 5-cycle gap mid-word
    do_reset(); got_wr.delete();
    run_image("stall", base, 50, 4, 5);

    // Reset after three payload bytes, then the full image
    do_reset(); got_wr.delete();
    for (int i = 0; i < 5; i++) send_byte(base[i], 100);
    do_reset();
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_nwr", 64'(got_wr.size()), 64'd0);
    chk("abort_cpu_rst", 64'(cpu_rst), 64'd1);
    run_image("abort_rerun", base, 100, -1, 0);

    // Full-size image (N = 2^AW): last write at the top address
    do_reset(); got_wr.delete();
    img.delete(); img.push_back(8'h00); img.push_back(8'h01);
    x = 8'h00;
    for (int i = 0; i < 4 * (1 << AW); i++) begin
      img.push_back(8'($urandom));
      x = x ^ img[img.size()-1];
    end
    img.push_back(x);
    run_image("full", img, 100, -1, 0);

    // Random images, some with corrupted checksums
    for (int t = 0; t < 8; t++) begin
      int n;
      do_reset(); got_wr.delete();
      n = $urandom_range(1, 6);
      img.delete(); img.push_back(8'(n)); img.push_back(8'h00);
      x = 8'h00;
      for (int i = 0; i < 4*n; i++) begin
        img.push_back(8'($urandom));
        x = x ^ img[img.size()-1];
      end
      img.push_back((t % 3 == 2) ? (x ^ 8'(1 << (t % 8))) : x);
      run_image($sformatf("rand%0d", t), img, 70, $urandom_range(2, 4*n+1), $urandom_range(0, 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
